// File: rtl/shifter_arbiter_pkg.sv
// Shared definitions for the shifter arbiter: widths, shift opcodes, FSM states
// and the captured-command payload. Also imported by the testbench.
package shifter_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] SHIFT_LSR = 2'b00;
    localparam logic [OP_W-1:0] SHIFT_ASR = 2'b01;
    localparam logic [OP_W-1:0] SHIFT_LSL = 2'b10;
    localparam logic [OP_W-1:0] SHIFT_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Command held in the operand registers while the shifter evaluates it
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [OP_W-1:0]   op;
        logic [AMT_W-1:0]  amt;
        logic              id;
    } cmd_t;

endpackage

// File: rtl/shifter_arbiter_shifter.sv
// Shared combinational barrel shifter. The illegal opcode passes the operand
// through; the arbiter is responsible for flagging it.
module Shifter
    import shifter_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [OP_W-1:0]   shiftop,
    input  logic [AMT_W-1:0]  shiftamt,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = in;
        case (shiftop)
            SHIFT_LSR: result = in >> shiftamt;
            SHIFT_ASR: result = DATA_W'($signed(in) >>> shiftamt);
            SHIFT_LSL: result = in << shiftamt;
            default:   result = in;
        endcase
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin sharing of one Shifter between two requesters, one command in
// flight, result returned on a registered response channel tagged with the ID.
module shifter_arbiter
    import shifter_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [AMT_W-1:0]  req0_amt,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [AMT_W-1:0]  req1_amt,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_id,
    output logic              rsp_err
);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    cmd_t              cmd_q, cmd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;

    logic [DATA_W-1:0] shift_res;
    logic              grant_id;

    Shifter u_shifter (
        .in       (cmd_q.data),
        .shiftop  (cmd_q.op),
        .shiftamt (cmd_q.amt),
        .result   (shift_res)
    );

    // Round-robin pick: on contention favour the requester not granted last
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is forced low while reset is asserted even though state already reads IDLE
    assign req0_ready = (state_q == ST_IDLE) && !reset && req0_valid && !grant_id;
    assign req1_ready = (state_q == ST_IDLE) && !reset && req1_valid &&  grant_id;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cmd_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req0_ready || req1_ready) begin
                    cmd_d.data   = grant_id ? req1_in  : req0_in;
                    cmd_d.op     = grant_id ? req1_op  : req0_op;
                    cmd_d.amt    = grant_id ? req1_amt : req0_amt;
                    cmd_d.id     = grant_id;
                    last_grant_d = grant_id;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_id_d    = cmd_q.id;
                rsp_valid_d = 1'b1;
                if (cmd_q.op == SHIFT_ILL) begin
                    rsp_result_d = cmd_q.data;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = shift_res;
                    rsp_err_d    = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed testbench for shifter_arbiter: hand-computed shift results, grant
// order, latency, back-pressure and reset-abort behaviour.
module tb_shifter_arbiter;
    import shifter_arbiter_pkg::*;

    logic              clk;
    logic              reset;
    logic              req0_valid, req0_ready;
    logic [DATA_W-1:0] req0_in;
    logic [OP_W-1:0]   req0_op;
    logic [AMT_W-1:0]  req0_amt;
    logic              req1_valid, req1_ready;
    logic [DATA_W-1:0] req1_in;
    logic [OP_W-1:0]   req1_op;
    logic [AMT_W-1:0]  req1_amt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_id;
    logic              rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    shifter_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_in    (req0_in),
        .req0_op    (req0_op),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_in    (req1_in),
        .req1_op    (req1_op),
        .req1_amt   (req1_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] d,
                           input logic [1:0] op, input logic [4:0] amt);
        if (n == 0) begin
            req0_valid = v; req0_in = d; req0_op = op; req0_amt = amt;
        end else begin
            req1_valid = v; req1_in = d; req1_op = op; req1_amt = amt;
        end
    endtask

    // Called at a negedge in IDLE with requests set up and rsp_ready high;
    // returns at the negedge three cycles later, back in IDLE.
    task automatic serve(input string tag, input logic exp_id,
                         input logic [31:0] exp_res, input logic exp_err);
        #1;
        check({tag, ".rdy0"}, 32'(req0_ready), 32'(!exp_id));
        check({tag, ".rdy1"}, 32'(req1_ready), 32'(exp_id));
        @(negedge clk); #1;
        check({tag, ".exec"}, {30'b0, req0_ready | req1_ready, rsp_valid}, 32'h0);
        @(negedge clk); #1;
        check({tag, ".valid"},  32'(rsp_valid), 32'h1);
        check({tag, ".result"}, rsp_result, exp_res);
        check({tag, ".id"},     32'(rsp_id), 32'(exp_id));
        check({tag, ".err"},    32'(rsp_err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'hDEAD_0000, SHIFT_LSR, 5'd1);
        set_req(1, 1'b1, 32'hBEEF_0000, SHIFT_LSR, 5'd1);
        repeat (2) @(negedge clk);
        #1;
        check("rst.valid",  32'(rsp_valid), 32'h0);
        check("rst.result", rsp_result, 32'h0);
        check("rst.id",     32'(rsp_id), 32'h0);
        check("rst.err",    32'(rsp_err), 32'h0);
        check("rst.rdy",    {30'b0, req1_ready, req0_ready}, 32'h0);
        @(negedge clk);
        set_req(0, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        set_req(1, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single-requester commands covering each op and the amount boundaries
        set_req(0, 1'b1, 32'h8000_00F0, SHIFT_ASR, 5'd4);
        serve("asr4", 1'b0, 32'hF800_000F, 1'b0);
        set_req(0, 1'b1, 32'h8000_0000, SHIFT_ASR, 5'd31);
        serve("asr31neg", 1'b0, 32'hFFFF_FFFF, 1'b0);
        set_req(0, 1'b1, 32'h7FFF_FFFF, SHIFT_ASR, 5'd31);
        serve("asr31pos", 1'b0, 32'h0000_0000, 1'b0);
        set_req(0, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        set_req(1, 1'b1, 32'hDEAD_BEEF, SHIFT_LSR, 5'd0);
        serve("amt0", 1'b1, 32'hDEAD_BEEF, 1'b0);
        set_req(1, 1'b1, 32'hFFFF_FFFF, SHIFT_LSL, 5'd4);
        serve("lsl4", 1'b1, 32'hFFFF_FFF0, 1'b0);
        set_req(1, 1'b1, 32'h1234_5678, SHIFT_ILL, 5'd7);
        serve("illegal", 1'b1, 32'h1234_5678, 1'b1);
        set_req(1, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        set_req(0, 1'b1, 32'h0000_00FF, SHIFT_LSL, 5'd8);
        serve("errclr", 1'b0, 32'h0000_FF00, 1'b0);

        // Fresh reset, then contention: requester 0 first, then strict alternation
        set_req(0, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, 32'h0000_0001, SHIFT_LSL, 5'd31);
        set_req(1, 1'b1, 32'hFFFF_FFFF, SHIFT_LSR, 5'd16);
        serve("both.first", 1'b0, 32'h8000_0000, 1'b0);
        serve("both.second", 1'b1, 32'h0000_FFFF, 1'b0);
        for (int i = 0; i < 6; i++) begin
            serve($sformatf("rr%0d", i), 1'(i % 2),
                  (i % 2 == 1) ? 32'h0000_FFFF : 32'h8000_0000, 1'b0);
        end

        // Back-pressure: response held while both requesters wait
        set_req(1, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        set_req(0, 1'b1, 32'hA5A5_0000, SHIFT_LSR, 5'd8);
        rsp_ready = 1'b0;
        #1;
        check("stall.rdy0", 32'(req0_ready), 32'h1);
        @(negedge clk);
        set_req(1, 1'b1, 32'h0F0F_0F0F, SHIFT_LSL, 5'd1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("stall%0d.valid", i),  32'(rsp_valid), 32'h1);
            check($sformatf("stall%0d.result", i), rsp_result, 32'h00A5_A500);
            check($sformatf("stall%0d.id_err", i), {30'b0, rsp_id, rsp_err}, 32'h0);
            check($sformatf("stall%0d.rdy", i),    {30'b0, req1_ready, req0_ready}, 32'h0);
            @(negedge clk);
        end
        // Requests withdrawn without ever being accepted
        set_req(0, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        set_req(1, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        rsp_ready = 1'b1;
        #1;
        check("release.held", 32'(rsp_valid), 32'h1);
        @(negedge clk); #1;
        check("release.idle", 32'(rsp_valid), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check($sformatf("withdrawn%0d", i), 32'(rsp_valid), 32'h0);
        end

        // Reset while a command is in EXEC: dropped, no response afterwards
        set_req(1, 1'b1, 32'hF0F0_F0F0, SHIFT_LSL, 5'd4);
        #1;
        check("abort.rdy1", 32'(req1_ready), 32'h1);
        @(negedge clk);
        set_req(1, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        reset = 1'b1;
        #1;
        check("abort.valid",  32'(rsp_valid), 32'h0);
        check("abort.result", rsp_result, 32'h0);
        check("abort.id_err", {30'b0, rsp_id, rsp_err}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b1, 32'h0000_0003, SHIFT_LSL, 5'd2);
        set_req(1, 1'b1, 32'hFFFF_0000, SHIFT_ASR, 5'd8);
        serve("post_rst", 1'b0, 32'h0000_000C, 1'b0);
        set_req(0, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        serve("post_rst2", 1'b1, 32'hFFFF_FF00, 1'b0);
        set_req(1, 1'b0, 32'h0, SHIFT_LSR, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("quiet%0d", i), 32'(rsp_valid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
